// File: rtl/bpu_btb_ras.sv
// Branch predictor: direct-mapped BTB with 2-bit counters and a non-speculative return stack.
// Define BPU_PERF_CNT_EN to add lookup/hit/mispredict performance counter outputs.
module bpu_btb_ras #(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned BTB_ENTRIES = 16,
    parameter int unsigned RAS_DEPTH   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            lkp_vld,
    input  logic [XLEN-1:0] lkp_pc,
    output logic            pred_vld,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_vld,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [7:0]      upd_jmp_type,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target
`ifdef BPU_PERF_CNT_EN
    ,
    output logic [31:0]     perf_lkp_cnt,
    output logic [31:0]     perf_hit_cnt,
    output logic [31:0]     perf_mispred_cnt
`endif
);
    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {KIND_BR, KIND_JMP, KIND_CALL, KIND_RET} kind_e;

    logic             valid_q [BTB_ENTRIES];
    logic [TAG_W-1:0] tag_q   [BTB_ENTRIES];
    logic [XLEN-1:0]  tgt_q   [BTB_ENTRIES];
    kind_e            kind_q  [BTB_ENTRIES];
    logic [1:0]       ctr_q   [BTB_ENTRIES];

    logic [XLEN-1:0]  ras_q   [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr_q, ras_ptr_d;
    logic [CNT_W-1:0] ras_cnt_q, ras_cnt_d;
    logic [XLEN-1:0]  ras_top;

    logic             pred_vld_q, pred_taken_q, pred_taken_d;
    logic [XLEN-1:0]  pred_target_q, pred_target_d;

    logic [IDX_W-1:0] lkp_idx;
    logic [TAG_W-1:0] lkp_tag;
    logic             lkp_hit;

    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_en, upd_hit;
    kind_e            upd_kind;

    logic             wr_en;
    logic [XLEN-1:0]  wr_tgt;
    kind_e            wr_kind;
    logic [1:0]       wr_ctr;

    logic             ras_pop, ras_push, ras_wr_en;
    logic [PTR_W-1:0] ras_wr_idx;
    logic [XLEN-1:0]  ras_link;
    logic             unused_pc_bits;

    assign unused_pc_bits = ^lkp_pc[1:0];

    assign lkp_idx = lkp_pc[IDX_W+1:2];
    assign lkp_tag = lkp_pc[XLEN-1:IDX_W+2];
    assign lkp_hit = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
    assign ras_top = ras_q[ras_ptr_q - PTR_W'(1)];

    // Lookup reads only _q state, so a same-cycle update is never visible here.
    always_comb begin
        pred_taken_d  = 1'b0;
        pred_target_d = '0;
        if (lkp_vld && lkp_hit) begin
            if (kind_q[lkp_idx] == KIND_BR) begin
                pred_taken_d = ctr_q[lkp_idx][1];
            end else begin
                pred_taken_d = 1'b1;
            end
            if (pred_taken_d) begin
                if (kind_q[lkp_idx] == KIND_RET && ras_cnt_q != '0) begin
                    pred_target_d = ras_top;
                end else begin
                    pred_target_d = tgt_q[lkp_idx];
                end
            end
        end
    end

    assign upd_en  = upd_vld && (upd_jmp_type != 8'h00);
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[XLEN-1:IDX_W+2];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    always_comb begin
        if (upd_jmp_type[3] || upd_jmp_type[5]) begin
            upd_kind = KIND_RET;
        end else if (upd_jmp_type[4]) begin
            upd_kind = KIND_CALL;
        end else if (upd_jmp_type[0]) begin
            upd_kind = KIND_BR;
        end else begin
            upd_kind = KIND_JMP;
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_tgt  = tgt_q[upd_idx];
        wr_kind = kind_q[upd_idx];
        wr_ctr  = ctr_q[upd_idx];
        if (upd_en) begin
            if (upd_hit) begin
                wr_en = 1'b1;
                if (kind_q[upd_idx] == KIND_BR) begin
                    if (upd_taken) begin
                        wr_ctr = (ctr_q[upd_idx] == 2'd3) ? 2'd3 : ctr_q[upd_idx] + 2'd1;
                    end else begin
                        wr_ctr = (ctr_q[upd_idx] == 2'd0) ? 2'd0 : ctr_q[upd_idx] - 2'd1;
                    end
                end
                if (upd_taken) begin
                    wr_tgt = upd_target;
                end
            end else if (upd_taken) begin
                wr_en   = 1'b1;
                wr_tgt  = upd_target;
                wr_kind = upd_kind;
                wr_ctr  = 2'b10;
            end
        end
    end

    assign ras_pop  = upd_en && (upd_jmp_type[3] || upd_jmp_type[5]);
    assign ras_push = upd_en && (upd_jmp_type[4] || upd_jmp_type[5]);
    assign ras_link = upd_pc + XLEN'(4);

    // Pop is applied first so ret_call replaces the top in place; an empty pop is a no-op.
    always_comb begin
        logic [PTR_W-1:0] ptr_p;
        logic [CNT_W-1:0] cnt_p;
        ptr_p = ras_ptr_q;
        cnt_p = ras_cnt_q;
        if (ras_pop && cnt_p != '0) begin
            ptr_p = ptr_p - PTR_W'(1);
            cnt_p = cnt_p - CNT_W'(1);
        end
        ras_ptr_d  = ptr_p;
        ras_cnt_d  = cnt_p;
        ras_wr_en  = 1'b0;
        ras_wr_idx = ptr_p;
        if (ras_push) begin
            ras_wr_en = 1'b1;
            ras_ptr_d = ptr_p + PTR_W'(1);
            ras_cnt_d = (cnt_p == CNT_W'(RAS_DEPTH)) ? cnt_p : cnt_p + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                kind_q[i]  <= KIND_BR;
                ctr_q[i]   <= '0;
            end
            for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
            ras_ptr_q     <= '0;
            ras_cnt_q     <= '0;
            pred_vld_q    <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
        end else begin
            if (wr_en) begin
                valid_q[upd_idx] <= 1'b1;
                tag_q[upd_idx]   <= upd_tag;
                tgt_q[upd_idx]   <= wr_tgt;
                kind_q[upd_idx]  <= wr_kind;
                ctr_q[upd_idx]   <= wr_ctr;
            end
            if (ras_wr_en) begin
                ras_q[ras_wr_idx] <= ras_link;
            end
            ras_ptr_q     <= ras_ptr_d;
            ras_cnt_q     <= ras_cnt_d;
            pred_vld_q    <= lkp_vld;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
        end
    end

    assign pred_vld    = pred_vld_q;
    assign pred_taken  = pred_taken_q;
    assign pred_target = pred_target_q;

`ifdef BPU_PERF_CNT_EN
    logic [31:0] perf_lkp_q, perf_hit_q, perf_mis_q;
    logic        upd_pred_taken, upd_mispred;

    assign upd_pred_taken = upd_hit && (kind_q[upd_idx] != KIND_BR || ctr_q[upd_idx][1]);
    assign upd_mispred    = upd_en && ((upd_pred_taken != upd_taken) ||
                                       (upd_taken && tgt_q[upd_idx] != upd_target));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_lkp_q <= '0;
            perf_hit_q <= '0;
            perf_mis_q <= '0;
        end else begin
            if (lkp_vld) begin
                perf_lkp_q <= perf_lkp_q + 32'd1;
            end
            if (lkp_vld && lkp_hit) begin
                perf_hit_q <= perf_hit_q + 32'd1;
            end
            if (upd_mispred) begin
                perf_mis_q <= perf_mis_q + 32'd1;
            end
        end
    end

    assign perf_lkp_cnt     = perf_lkp_q;
    assign perf_hit_cnt     = perf_hit_q;
    assign perf_mispred_cnt = perf_mis_q;
`endif

endmodule

// File: tb/tb_bpu_btb_ras.sv
// Self-checking bench for bpu_btb_ras: directed vector table, hand sequences, random vs reference model.
module tb_bpu_btb_ras;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lkp_vld = 1'b0;
    logic [63:0] lkp_pc = '0;
    logic        pred_vld, pred_taken;
    logic [63:0] pred_target;
    logic        upd_vld = 1'b0;
    logic [63:0] upd_pc = '0;
    logic [7:0]  upd_jmp_type = '0;
    logic        upd_taken = 1'b0;
    logic [63:0] upd_target = '0;
`ifdef BPU_PERF_CNT_EN
    logic [31:0] perf_lkp_cnt, perf_hit_cnt, perf_mispred_cnt;
`endif

    bpu_btb_ras #(.XLEN(64), .BTB_ENTRIES(16), .RAS_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .lkp_vld(lkp_vld), .lkp_pc(lkp_pc),
        .pred_vld(pred_vld), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_vld(upd_vld), .upd_pc(upd_pc), .upd_jmp_type(upd_jmp_type),
        .upd_taken(upd_taken), .upd_target(upd_target)
`ifdef BPU_PERF_CNT_EN
        , .perf_lkp_cnt(perf_lkp_cnt), .perf_hit_cnt(perf_hit_cnt),
        .perf_mispred_cnt(perf_mispred_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: entries keep the full PC; RAS is a bounded queue, newest at the back.
    typedef struct { bit v; logic [63:0] pc; logic [63:0] tgt; int kind; int ctr; } ment_t;
    ment_t       mbtb [16];
    logic [63:0] mras [$];

    typedef struct {
        logic lv; logic [63:0] lpc;
        logic uv; logic [63:0] upc; logic [7:0] ut; logic utk; logic [63:0] utg;
        logic ev; logic etk; logic [63:0] etg;
    } vec_t;
    vec_t tbl [$];

    function automatic vec_t mk(input logic lv, input logic [63:0] lpc, input logic uv,
                                input logic [63:0] upc, input logic [7:0] ut, input logic utk,
                                input logic [63:0] utg, input logic ev, input logic etk,
                                input logic [63:0] etg);
        vec_t r;
        r.lv = lv; r.lpc = lpc; r.uv = uv; r.upc = upc; r.ut = ut; r.utk = utk; r.utg = utg;
        r.ev = ev; r.etk = etk; r.etg = etg;
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            mbtb[i].v = 0; mbtb[i].pc = '0; mbtb[i].tgt = '0; mbtb[i].kind = 0; mbtb[i].ctr = 0;
        end
        mras.delete();
    endfunction

    function automatic logic [64:0] model_pred(input logic [63:0] pc);
        int i;
        logic [64:0] r;
        i = int'(pc[5:2]);
        r = '0;
        if (mbtb[i].v && (mbtb[i].pc >> 2) == (pc >> 2)) begin
            if (mbtb[i].kind == 0) r = (mbtb[i].ctr >= 2) ? {1'b1, mbtb[i].tgt} : '0;
            else if (mbtb[i].kind == 3 && mras.size() > 0) r = {1'b1, mras[$]};
            else r = {1'b1, mbtb[i].tgt};
        end
        return r;
    endfunction

    function automatic void model_update(input logic uv, input logic [63:0] pc, input logic [7:0] t,
                                         input logic tk, input logic [63:0] tg);
        int i;
        int k;
        if (!uv || t == 8'h00) return;
        i = int'(pc[5:2]);
        k = (t[3] || t[5]) ? 3 : t[4] ? 2 : t[0] ? 0 : 1;
        if (mbtb[i].v && (mbtb[i].pc >> 2) == (pc >> 2)) begin
            if (mbtb[i].kind == 0) begin
                if (tk) mbtb[i].ctr = (mbtb[i].ctr < 3) ? mbtb[i].ctr + 1 : 3;
                else    mbtb[i].ctr = (mbtb[i].ctr > 0) ? mbtb[i].ctr - 1 : 0;
            end
            if (tk) mbtb[i].tgt = tg;
        end else if (tk) begin
            mbtb[i].v = 1; mbtb[i].pc = pc; mbtb[i].tgt = tg; mbtb[i].kind = k; mbtb[i].ctr = 2;
        end
        if ((t[3] || t[5]) && mras.size() > 0) void'(mras.pop_back());
        if (t[4] || t[5]) begin
            mras.push_back(pc + 64'd4);
            if (mras.size() > 8) void'(mras.pop_front());
        end
    endfunction

    task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got {vld,taken,target}=%h want %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic lv, input logic [63:0] lpc, input logic uv,
                        input logic [63:0] upc, input logic [7:0] ut, input logic utk,
                        input logic [63:0] utg, input logic use_exp, input logic [65:0] exp_in,
                        input string nm);
        logic [65:0] e;
        lkp_vld = lv; lkp_pc = lpc;
        upd_vld = uv; upd_pc = upc; upd_jmp_type = ut; upd_taken = utk; upd_target = utg;
        if (use_exp) e = exp_in;
        else e = lv ? {1'b1, model_pred(lpc)} : '0;
        model_update(uv, upc, ut, utk, utg);
        @(posedge clk);
        #1;
        chk(nm, {pred_vld, pred_taken, pred_target}, e);
        @(negedge clk);
        lkp_vld = 1'b0; upd_vld = 1'b0;
    endtask

    function automatic logic [63:0] rpc();
        if ($urandom_range(0, 15) == 0) return {$urandom, $urandom};
        return 64'h8000_0000 + (64'($urandom_range(0, 63)) << 2);
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [63:0] B  = 64'h8000_0010;
    localparam logic [63:0] T  = 64'h8000_0100;
    localparam logic [63:0] RP = 64'h8000_0200;
    localparam logic [63:0] R4 = 64'h8000_3000;
    localparam logic [63:0] P5 = 64'h9000_004C;

    initial begin
        logic [65:0] e4;
        logic [7:0]  tl [9];
        logic        lv, utk;
        logic [63:0] lpc, upc, utg;
        logic [7:0]  ut;
        int          sel;

        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("reset_state", {pred_vld, pred_taken, pred_target}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        tbl.push_back(mk(1, 64'h8000_0000, 0, 0, 8'h00, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, B, 8'h01, 1, T, 0, 0, 0));
        tbl.push_back(mk(1, B, 0, 0, 8'h00, 0, 0, 1, 1, T));
        tbl.push_back(mk(1, B, 1, B, 8'h01, 0, 0, 1, 1, T));
        tbl.push_back(mk(1, B, 1, B, 8'h01, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, B, 1, B, 8'h01, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, B, 1, B, 8'h01, 1, T, 1, 0, 0));
        tbl.push_back(mk(1, B, 1, B, 8'h01, 1, T, 1, 0, 0));
        tbl.push_back(mk(1, B, 1, B, 8'h01, 1, T, 1, 1, T));
        tbl.push_back(mk(0, 0, 1, B, 8'h01, 1, T, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, B, 8'h01, 1, T, 0, 0, 0));
        tbl.push_back(mk(1, B, 1, B, 8'h01, 0, 0, 1, 1, T));
        tbl.push_back(mk(1, B, 0, 0, 8'h00, 0, 0, 1, 1, T));
        tbl.push_back(mk(1, B, 1, B, 8'h01, 0, 0, 1, 1, T));
        tbl.push_back(mk(1, B, 0, 0, 8'h00, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 64'h8000_0080, 8'h00, 1, 64'h1111_0000, 0, 0, 0));
        tbl.push_back(mk(1, 64'h8000_0080, 0, 0, 8'h00, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 64'h8000_0030, 8'h01, 0, 64'h2222_0000, 0, 0, 0));
        tbl.push_back(mk(1, 64'h8000_0030, 0, 0, 8'h00, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 64'h8000_0044, 8'h04, 1, 64'h9000_0000, 0, 0, 0));
        tbl.push_back(mk(1, 64'h8000_0044, 0, 0, 8'h00, 0, 0, 1, 1, 64'h9000_0000));
        tbl.push_back(mk(1, 64'h8000_0084, 0, 0, 8'h00, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 64'h8000_0044, 8'h04, 1, 64'h9000_0040, 0, 0, 0));
        tbl.push_back(mk(1, 64'h8000_0044, 0, 0, 8'h00, 0, 0, 1, 1, 64'h9000_0040));
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].lv, tbl[i].lpc, tbl[i].uv, tbl[i].upc, tbl[i].ut, tbl[i].utk, tbl[i].utg,
                 1'b1, {tbl[i].ev, tbl[i].etk, tbl[i].etg}, $sformatf("vec%0d", i));
        end

        step(0, 0, 1, 64'h8000_0020, 8'h10, 1, 64'h8000_1000, 1, '0, "t3_call");
        step(0, 0, 1, RP, 8'h08, 1, 64'h8000_0024, 1, '0, "t3_ret_upd");
        step(1, RP, 0, 0, 8'h00, 0, 0, 1, {2'b11, 64'h8000_0024}, "t3_ret_lkp");
        step(0, 0, 1, 64'h8000_0508, 8'h10, 1, 64'h8000_2000, 1, '0, "t3_call2");
        step(1, RP, 0, 0, 8'h00, 0, 0, 1, {2'b11, 64'h8000_050C}, "t3_ras_top");
        step(0, 0, 1, RP, 8'h08, 1, 64'h8000_0777, 1, '0, "t3_ret2");
        step(1, RP, 0, 0, 8'h00, 0, 0, 1, {2'b11, 64'h8000_0777}, "t3_ras_empty");
        step(0, 0, 1, 64'h8000_0614, 8'h20, 1, 64'h8000_3000, 1, '0, "t3_rc_empty");
        step(0, 0, 1, 64'h8000_0718, 8'h10, 1, 64'h8000_4000, 1, '0, "t3_call3");
        step(0, 0, 1, 64'h8000_081C, 8'h20, 1, 64'h8000_5000, 1, '0, "t3_rc");
        step(1, RP, 0, 0, 8'h00, 0, 0, 1, {2'b11, 64'h8000_0820}, "t3_rc_top");
        step(0, 0, 1, RP, 8'h08, 1, 64'h8000_0888, 1, '0, "t3_ret3");
        step(1, RP, 0, 0, 8'h00, 0, 0, 1, {2'b11, 64'h8000_0618}, "t3_rc_cnt");
        step(0, 0, 1, RP, 8'h08, 1, 64'h8000_0999, 1, '0, "t3_ret4");
        step(1, RP, 1, 64'h8000_0920, 8'h10, 1, 64'h8000_6000, 1, {2'b11, 64'h8000_0999}, "t3_ras_rbw");
        step(1, RP, 0, 0, 8'h00, 0, 0, 1, {2'b11, 64'h8000_0924}, "t3_ras_after");
        step(0, 0, 1, RP, 8'h08, 1, 64'h8000_0924, 1, '0, "t3_drain");

        step(0, 0, 1, R4, 8'h08, 1, 64'hDEAD_0F00, 1, '0, "t4_alloc_ret");
        for (int i = 0; i < 9; i++) begin
            step(0, 0, 1, 64'h8001_0004 + 64'(i) * 64'h40, 8'h10, 1, 64'h8100_0000, 1, '0, "t4_call");
        end
        for (int k = 0; k < 9; k++) begin
            if (k < 8) e4 = {2'b11, 64'h8001_0008 + 64'(8 - k) * 64'h40};
            else       e4 = {2'b11, 64'hDEAD_0070};
            step(1, R4, 1, R4, 8'h08, 1, 64'hDEAD_0000 + 64'(k) * 64'h10, 1, e4,
                 $sformatf("t4_ret%0d", k));
        end
        step(1, R4, 0, 0, 8'h00, 0, 0, 1, {2'b11, 64'hDEAD_0080}, "t4_empty");

        step(1, P5, 1, P5, 8'h04, 1, 64'hA000_0000, 1, {2'b10, 64'h0}, "t5_same_cycle");
        step(1, P5, 0, 0, 8'h00, 0, 0, 1, {2'b11, 64'hA000_0000}, "t5_next");

        tl[0] = 8'h00; tl[1] = 8'h01; tl[2] = 8'h02; tl[3] = 8'h04; tl[4] = 8'h08;
        tl[5] = 8'h10; tl[6] = 8'h20; tl[7] = 8'h18; tl[8] = 8'h80;
        for (int i = 0; i < 400; i++) begin
            lv  = ($urandom_range(0, 9) < 7);
            upc = rpc();
            lpc = ($urandom_range(0, 3) == 0) ? upc : rpc();
            sel = $urandom_range(0, 9);
            ut  = (sel < 9) ? tl[sel] : 8'($urandom);
            utk = (sel >= 2 && sel <= 7) ? ($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 1));
            utg = {$urandom, $urandom};
            step(lv, lpc, $urandom_range(0, 4) != 0, upc, ut, utk, utg, 1'b0, '0, "rand");
        end

        lkp_vld = 1'b1; lkp_pc = P5;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_clear", {pred_vld, pred_taken, pred_target}, '0);
        @(posedge clk);
        #1;
        chk("t6_in_reset", {pred_vld, pred_taken, pred_target}, '0);
        @(negedge clk);
        lkp_vld = 1'b0;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        chk("t6_no_pred", {pred_vld, pred_taken, pred_target}, '0);
`ifdef BPU_PERF_CNT_EN
        chk("t6_perf_lkp", 66'(perf_lkp_cnt), '0);
        chk("t6_perf_hit", 66'(perf_hit_cnt), '0);
        chk("t6_perf_mis", 66'(perf_mispred_cnt), '0);
`endif
        @(negedge clk);
        step(1, P5, 0, 0, 8'h00, 0, 0, 1, {2'b10, 64'h0}, "t6_btb_empty");
        step(1, R4, 0, 0, 8'h00, 0, 0, 1, {2'b10, 64'h0}, "t6_btb_empty2");
`ifdef BPU_PERF_CNT_EN
        chk("t6_perf_lkp2", 66'(perf_lkp_cnt), 66'd2);
        chk("t6_perf_hit2", 66'(perf_hit_cnt), '0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
